// File: rtl/vga_sync_capture.sv
// rtl/vga_sync_capture.sv - VGA receive side: timing measurement, lock FSM, pixel coordinate recovery
module vga_sync_capture #(
  parameter int V_BP        = 31,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       VGA_CLK,
  input  logic       Reset,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_N,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] Pix_X,
  output logic [9:0] Pix_Y,
  output logic       Pix_Valid,
  output logic [7:0] Red_o,
  output logic [7:0] Green_o,
  output logic [7:0] Blue_o,
  output logic       Locked,
  output logic [9:0] H_Total,
  output logic [9:0] V_Total,
  output logic [9:0] Act_Width,
  output logic       Frame_Done,
  output logic       Sync_Err
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCKED} state_t;

  localparam logic [9:0] H_MAX    = 10'h3ff;
  localparam logic [9:0] ROW_BP   = 10'(V_BP);
  localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] ROW_END  = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

  state_t     state, state_n;
  logic       s1_hs, s1_vs, s1_blank;
  logic       p_hs, p_vs, p_blank;
  logic [7:0] s1_red, s1_green, s1_blue;
  logic       hs_fall, vs_fall, vs_rise, bl_rise, bl_fall;
  logic [9:0] h_cnt, line_cnt, last_period, hs_period;
  logic [9:0] run_cnt, x_cnt, x_n;
  logic [9:0] row, row_n, row_skip, row_skip_n;
  logic       rows_on, rows_on_n, row_started, row_started_n;
  logic [7:0] verify_cnt, verify_n;
  logic       violation, lock_ok, valid_n, done_n;

  assign hs_fall   = p_hs & ~s1_hs;
  assign vs_fall   = p_vs & ~s1_vs;
  assign vs_rise   = ~p_vs & s1_vs;
  assign bl_rise   = ~p_blank & s1_blank;
  assign bl_fall   = p_blank & ~s1_blank;
  assign hs_period = h_cnt + 10'd1;
  assign Locked    = (state == ST_LOCKED);
  assign lock_ok   = Locked & ~violation;

  always_ff @(posedge VGA_CLK) begin
    if (Reset) state <= ST_SEARCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    verify_n  = verify_cnt;
    violation = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) state_n = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (h_cnt == H_MAX) begin
          violation = 1'b1;
        end else if (vs_fall) begin
          state_n  = ST_VERIFY;
          verify_n = 8'd0;
        end
      end
      ST_VERIFY, ST_LOCKED: begin
        if (h_cnt == H_MAX || (hs_fall && hs_period != H_Total) ||
            (vs_fall && line_cnt != V_Total)) begin
          violation = 1'b1;
        end else if (vs_fall && state == ST_VERIFY) begin
          verify_n = verify_cnt + 8'd1;
          if (verify_n >= LOCK_N) state_n = ST_LOCKED;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
    if (violation) begin
      state_n  = ST_SEARCH;
      verify_n = 8'd0;
    end
  end

  // Row tracking is resolved combinationally so the row that starts on this
  // BLANK_N rise already applies to its first pixel.
  always_comb begin
    row_n         = row;
    row_skip_n    = row_skip;
    rows_on_n     = rows_on;
    row_started_n = row_started;
    if (vs_rise) begin
      row_n         = 10'd0;
      row_skip_n    = ROW_BP;
      rows_on_n     = 1'b0;
      row_started_n = 1'b0;
    end else if (bl_rise) begin
      if (row_skip != 10'd0) begin
        row_skip_n = row_skip - 10'd1;
      end else if (!row_started) begin
        row_started_n = 1'b1;
        rows_on_n     = 1'b1;
      end else if (rows_on) begin
        row_n = row + 10'd1;
      end
    end else if (bl_fall && rows_on && row == ROW_LAST) begin
      rows_on_n = 1'b0;
    end
    x_n     = bl_rise ? 10'd0 : x_cnt;
    valid_n = lock_ok & s1_blank & rows_on_n & (row_n < ROW_END);
    done_n  = lock_ok & bl_fall & rows_on & (row == ROW_LAST);
  end

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_blank <= 1'b0;
      p_hs <= 1'b0; p_vs <= 1'b0; p_blank <= 1'b0;
      s1_red <= 8'd0; s1_green <= 8'd0; s1_blue <= 8'd0;
      h_cnt <= 10'd0; line_cnt <= 10'd0; last_period <= 10'd0;
      run_cnt <= 10'd0; x_cnt <= 10'd0;
      row <= 10'd0; row_skip <= 10'd0; rows_on <= 1'b0; row_started <= 1'b0;
      verify_cnt <= 8'd0;
      H_Total <= 10'd0; V_Total <= 10'd0; Act_Width <= 10'd0;
      Pix_X <= 10'd0; Pix_Y <= 10'd0; Pix_Valid <= 1'b0;
      Red_o <= 8'd0; Green_o <= 8'd0; Blue_o <= 8'd0;
      Frame_Done <= 1'b0; Sync_Err <= 1'b0;
    end else begin
      s1_hs    <= VGA_HS;
      s1_vs    <= VGA_VS;
      s1_blank <= VGA_BLANK_N;
      s1_red   <= Red;
      s1_green <= Green;
      s1_blue  <= Blue;
      p_hs     <= s1_hs;
      p_vs     <= s1_vs;
      p_blank  <= s1_blank;

      if (hs_fall)             h_cnt <= 10'd0;
      else if (h_cnt != H_MAX) h_cnt <= h_cnt + 10'd1;
      if (hs_fall) last_period <= hs_period;
      if (vs_fall)      line_cnt <= 10'd0;
      else if (hs_fall) line_cnt <= line_cnt + 10'd1;

      verify_cnt <= verify_n;
      Sync_Err   <= violation;
      if (state == ST_MEASURE && vs_fall && !violation) begin
        H_Total <= hs_fall ? hs_period : last_period;
        V_Total <= line_cnt;
      end

      if (bl_rise)       run_cnt <= 10'd1;
      else if (s1_blank) run_cnt <= run_cnt + 10'd1;
      if (bl_fall) Act_Width <= run_cnt;

      row         <= row_n;
      row_skip    <= row_skip_n;
      rows_on     <= rows_on_n;
      row_started <= row_started_n;
      x_cnt       <= s1_blank ? x_n + 10'd1 : x_n;

      Pix_Valid  <= valid_n;
      Frame_Done <= done_n;
      if (valid_n) begin
        Pix_X   <= x_n;
        Pix_Y   <= row_n;
        Red_o   <= s1_red;
        Green_o <= s1_green;
        Blue_o  <= s1_blue;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_capture.sv
// tb/tb_vga_sync_capture.sv - scoreboard bench for vga_sync_capture on a reduced 40x14 raster
module tb_vga_sync_capture;

  localparam int H_TOT  = 40;
  localparam int H_ACT  = 16;
  localparam int HS_BEG = 24;
  localparam int HS_END = 31;
  localparam int V_TOT  = 14;
  localparam int V_ACT  = 8;
  localparam int VS_BEG = 10;
  localparam int VS_END = 12;
  localparam int VS_CLK = 20;

  logic       VGA_CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       VGA_HS = 1'b1;
  logic       VGA_VS = 1'b1;
  logic       VGA_BLANK_N = 1'b0;
  logic [7:0] Red = 8'd0, Green = 8'd0, Blue = 8'd0;
  logic [9:0] Pix_X, Pix_Y, H_Total, V_Total, Act_Width;
  logic       Pix_Valid, Locked, Frame_Done, Sync_Err;
  logic [7:0] Red_o, Green_o, Blue_o;

  vga_sync_capture #(.V_BP(1), .V_ACTIVE(V_ACT), .LOCK_FRAMES(2)) dut (
    .VGA_CLK(VGA_CLK), .Reset(Reset), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .Red(Red), .Green(Green), .Blue(Blue),
    .Pix_X(Pix_X), .Pix_Y(Pix_Y), .Pix_Valid(Pix_Valid),
    .Red_o(Red_o), .Green_o(Green_o), .Blue_o(Blue_o), .Locked(Locked),
    .H_Total(H_Total), .V_Total(V_Total), .Act_Width(Act_Width),
    .Frame_Done(Frame_Done), .Sync_Err(Sync_Err)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t pix_q[$];
  int   fd_q[$];
  int   se_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   pix_seen = 0;
  int   last_hs = 0;

  always @(posedge VGA_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, int'(|{Pix_X, Pix_Y, Pix_Valid, Red_o, Green_o, Blue_o, Locked,
                     H_Total, V_Total, Act_Width, Frame_Done, Sync_Err}), 0);
  endtask

  // Monitor: every DUT output event pops its expectation from the matching queue.
  always @(negedge VGA_CLK) begin
    pix_t e;
    int   c;
    if (Pix_Valid) begin
      pix_seen++;
      if (pix_q.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        e = pix_q.pop_front();
        chk("pix_x", int'(Pix_X), e.x);
        chk("pix_y", int'(Pix_Y), e.y);
        chk("red_o", int'(Red_o), e.x & 255);
        chk("green_o", int'(Green_o), e.y & 255);
        chk("blue_o", int'(Blue_o), 8'hA5);
        chk("pix_latency_cycle", cyc, e.c);
      end
    end
    if (Frame_Done) begin
      if (fd_q.size() == 0) chk("frame_done_unexpected", 1, 0);
      else begin
        c = fd_q.pop_front();
        chk("frame_done_cycle", cyc, c);
      end
    end
    if (Sync_Err) begin
      if (se_q.size() == 0) chk("sync_err_unexpected", 1, 0);
      else begin
        c = se_q.pop_front();
        chk("sync_err_cycle", cyc, c);
        chk("sync_err_locked", int'(Locked), 0);
        chk("sync_err_pix_valid", int'(Pix_Valid), 0);
      end
    end
  end

  task automatic drive_idle();
    VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
    Red = 8'd0; Green = 8'd0; Blue = 8'd0;
  endtask

  task automatic reset_dut();
    @(negedge VGA_CLK);
    Reset = 1'b1;
    drive_idle();
    @(negedge VGA_CLK);
    check_zero("reset_outputs");
    Reset = 1'b0;
  endtask

  // One raster frame: lk_in = DUT expected locked while pixels stream,
  // lk_out = expected Locked after the frame's VS fall.
  task automatic run_frame(input bit lk_in, input bit lk_out, input int drop_line,
                           input int rst_line, input int rst_clk);
    bit rst_pend, cut, vs_low;
    rst_pend = 1'b0;
    for (int ln = 0; ln < V_TOT; ln++) begin
      for (int c = 0; c < H_TOT; c++) begin
        @(negedge VGA_CLK);
        if (rst_pend) begin
          check_zero("midrow_reset_outputs");
          rst_pend = 1'b0;
        end
        vs_low = (ln == VS_BEG && c >= VS_CLK) || (ln > VS_BEG && ln < VS_END) ||
                 (ln == VS_END && c < VS_CLK);
        Reset       = (ln == rst_line && c == rst_clk);
        VGA_HS      = !(c >= HS_BEG && c <= HS_END && ln != drop_line);
        VGA_VS      = !vs_low;
        VGA_BLANK_N = (c < H_ACT);
        Red         = 8'(c);
        Green       = 8'(ln);
        Blue        = 8'hA5;
        if (!VGA_HS && c == HS_BEG) last_hs = cyc;
        if (Reset) rst_pend = 1'b1;
        if (drop_line >= 0 && ln == drop_line + 1 && c == HS_BEG) se_q.push_back(cyc + 2);
        cut = (drop_line >= 0 && ln >= drop_line + 2) ||
              (rst_line >= 0 && (ln > rst_line || (ln == rst_line && c >= rst_clk - 1)));
        if (lk_in && VGA_BLANK_N && ln < V_ACT && !cut) pix_q.push_back('{c, ln, cyc + 2});
        if (lk_in && drop_line < 0 && rst_line < 0 && ln == V_ACT - 1 && c == H_ACT - 1)
          fd_q.push_back(cyc + 3);
      end
    end
    chk("locked_end_of_frame", int'(Locked), int'(lk_out));
  endtask

  task automatic lock_sequence();
    run_frame(1'b0, 1'b0, -1, -1, 0);
    run_frame(1'b0, 1'b0, -1, -1, 0);
    run_frame(1'b0, 1'b1, -1, -1, 0);
  endtask

  initial begin
    drive_idle();
    Reset = 1'b1;
    repeat (3) @(negedge VGA_CLK);
    check_zero("power_on_reset_outputs");
    Reset = 1'b0;

    // Lock acquisition and measurement
    run_frame(1'b0, 1'b0, -1, -1, 0);
    lock_sequence();
    chk("h_total", int'(H_Total), 40);
    chk("v_total", int'(V_Total), 14);
    chk("act_width", int'(Act_Width), 16);

    // One fully locked frame: 16x8 pixels, RGB pattern, one Frame_Done
    pix_seen = 0;
    run_frame(1'b1, 1'b1, -1, -1, 0);
    chk("valid_pixel_count", pix_seen, 128);

    // Dropped HS pulse on line 3, then relock after three clean frames
    run_frame(1'b1, 1'b0, 3, -1, 0);
    lock_sequence();
    run_frame(1'b1, 1'b1, -1, -1, 0);
    chk("h_total_after_relock", int'(H_Total), 40);

    // HS stuck high while measuring
    reset_dut();
    run_frame(1'b0, 1'b0, -1, -1, 0);
    se_q.push_back(last_hs + 1026);
    for (int i = 0; i < 1100; i++) begin
      @(negedge VGA_CLK);
      drive_idle();
    end
    chk("locked_after_stuck_hs", int'(Locked), 0);
    run_frame(1'b0, 1'b0, -1, -1, 0);
    lock_sequence();
    run_frame(1'b1, 1'b1, -1, -1, 0);

    // Reset mid-row while locked, then relock
    run_frame(1'b1, 1'b0, -1, 3, 8);
    lock_sequence();
    run_frame(1'b1, 1'b1, -1, -1, 0);
    chk("v_total_final", int'(V_Total), 14);

    repeat (4) @(negedge VGA_CLK);
    chk("pix_queue_left", pix_q.size(), 0);
    chk("frame_done_queue_left", fd_q.size(), 0);
    chk("sync_err_queue_left", se_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
